// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell (two half adders + OR) fed by a
// carry flop, consuming one operand bit per clock LSB first, with start/busy/done.

module serial_addsub_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);
  localparam int CNT_W = $clog2(WIDTH+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sa_q, sb_q, res_q, res_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               carry_q;
  logic               busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]   sum_q;
  logic               p, g0, s, g1, c;

  serial_addsub_ha u_ha0 (.x_i(sa_q[0]), .y_i(sb_q[0]), .s_o(p), .c_o(g0));
  serial_addsub_ha u_ha1 (.x_i(p),       .y_i(carry_q), .s_o(s), .c_o(g1));
  assign c     = g0 | g1;
  assign res_d = {s, res_q[WIDTH-1:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            // subtraction as a + ~b + 1: the +1 enters through the initial carry
            sa_q    <= a_i;
            sb_q    <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          res_q   <= res_d;
          carry_q <= c;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            // carry_q here is still the carry into the MSB
            sum_q   <= res_d;
            cout_q  <= c;
            ovf_q   <= carry_q ^ c;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
endmodule
